// File: rtl/text_overlay_sequencer.sv
// Per-frame text overlay sequencer: slide in, hold, blink, slide out.
// Drives a shifted x coordinate to the text ROM and gates its pixel output.
module text_overlay_sequencer #(
    parameter int SLIDE_MAX    = 640,
    parameter int SLIDE_STEP   = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 64,
    parameter int BLINK_SHIFT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       abort,
    input  logic [9:0] x,
    input  logic       overlay_in,
    output logic [9:0] x_out,
    output logic       overlay_out,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CNT_LOG = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Widen if needed so the blink phase bit always exists in the counter.
    localparam int CNT_W   = (CNT_LOG > BLINK_SHIFT) ? CNT_LOG : BLINK_SHIFT + 1;

    localparam logic [9:0]       OFF_MAX    = 10'(SLIDE_MAX);
    localparam logic [10:0]      OFF_MAX11  = 11'(SLIDE_MAX);
    localparam logic [10:0]      STEP11     = 11'(SLIDE_STEP);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSlideIn,
        StHold,
        StBlink,
        StSlideOut
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       offset_q, offset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             text_en_q, text_en_d;
    logic             start_pend_q, start_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [10:0]      off_up;

    assign off_up = {1'b0, offset_q} + STEP11;

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        cnt_d        = cnt_q;
        start_pend_d = start_pend_q;
        done_d       = 1'b0;

        if (state_q == StIdle && start) begin
            start_pend_d = 1'b1;
        end

        if (frame_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (start || start_pend_q) begin
                        state_d      = StSlideIn;
                        offset_d     = OFF_MAX;
                        start_pend_d = 1'b0;
                    end
                end
                StSlideIn: begin
                    if ({1'b0, offset_q} <= STEP11) begin
                        offset_d = 10'd0;
                        state_d  = StHold;
                        cnt_d    = '0;
                    end else begin
                        offset_d = offset_q - STEP11[9:0];
                    end
                end
                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = StBlink;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StBlink: begin
                    if (cnt_q == BLINK_LAST) begin
                        state_d = StSlideOut;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StSlideOut: begin
                    if (off_up >= OFF_MAX11) begin
                        offset_d = OFF_MAX;
                        state_d  = StIdle;
                        done_d   = 1'b1;
                    end else begin
                        offset_d = off_up[9:0];
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Abort wins over start and frame_tick.
        if (abort) begin
            state_d      = StIdle;
            offset_d     = OFF_MAX;
            cnt_d        = '0;
            start_pend_d = 1'b0;
            done_d       = 1'b0;
        end

        unique case (state_d)
            StIdle:  text_en_d = 1'b0;
            StBlink: text_en_d = ~cnt_d[BLINK_SHIFT];
            default: text_en_d = 1'b1;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            offset_q     <= OFF_MAX;
            cnt_q        <= '0;
            text_en_q    <= 1'b0;
            start_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            cnt_q        <= cnt_d;
            text_en_q    <= text_en_d;
            start_pend_q <= start_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // x < offset wraps in x_out; the compare masks that region.
    assign x_out       = x - offset_q;
    assign overlay_out = text_en_q & overlay_in & (x >= offset_q);
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_text_overlay_sequencer.sv
// Scoreboard bench for text_overlay_sequencer with a small-parameter configuration.
module tb_text_overlay_sequencer;

    localparam int SM = 16;
    localparam int ST = 4;
    localparam int HF = 4;
    localparam int BF = 4;
    localparam int BS = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, start, abort;
    logic [9:0] x;
    logic       overlay_in;
    logic [9:0] x_out;
    logic       overlay_out, busy, done;

    text_overlay_sequencer #(
        .SLIDE_MAX   (SM),
        .SLIDE_STEP  (ST),
        .HOLD_FRAMES (HF),
        .BLINK_FRAMES(BF),
        .BLINK_SHIFT (BS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .abort      (abort),
        .x          (x),
        .overlay_in (overlay_in),
        .x_out      (x_out),
        .overlay_out(overlay_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int off;
        bit en;
        bit busy;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: 0 idle, 1 slide-in, 2 hold, 3 blink, 4 slide-out
    int m_st, m_off, m_cnt;
    bit m_pend;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_off = SM; m_cnt = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit a);
        exp_t e;
        bit   d = 0;
        if (a) begin
            model_reset();
        end else begin
            if (m_st == 0 && s) m_pend = 1;
            if (t) begin
                case (m_st)
                    0: if (m_pend) begin m_st = 1; m_off = SM; m_pend = 0; end
                    1: if (m_off - ST <= 0) begin m_off = 0; m_st = 2; m_cnt = 0; end
                       else m_off = m_off - ST;
                    2: if (m_cnt == HF - 1) begin m_st = 3; m_cnt = 0; end
                       else m_cnt++;
                    3: if (m_cnt == BF - 1) begin m_st = 4; m_cnt = 0; end
                       else m_cnt++;
                    4: if (m_off + ST >= SM) begin m_off = SM; m_st = 0; d = 1; end
                       else m_off = m_off + ST;
                    default: m_st = 0;
                endcase
            end
        end
        e.off  = m_off;
        e.busy = (m_st != 0);
        e.done = d;
        if (m_st == 0)      e.en = 0;
        else if (m_st == 3) e.en = ((m_cnt >> BS) & 1) == 0;
        else                e.en = 1;
        sb.push_back(e);
    endtask

    // Probe offset via x_out at x=0 and text_en via overlay_out at x=1023.
    task automatic compare_outputs(input exp_t e);
        logic [9:0] xo;
        xo = 10'd0 - 10'(e.off);
        x = 10'd0; overlay_in = 1'b1;
        #1 check_eq("x_out_offset", x_out, xo);
        x = 10'd1023;
        #1 check_eq("text_en", overlay_out, e.en);
        check_eq("busy", busy, e.busy);
        check_eq("done", done, e.done);
        x = 10'd0;
    endtask

    task automatic cycle(input bit t, input bit s, input bit a);
        exp_t e;
        @(negedge clk);
        frame_tick = t; start = s; abort = a;
        model_step(t, s, a);
        @(posedge clk);
        #1;
        frame_tick = 0; start = 0; abort = 0;
        check_eq("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare_outputs(e);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
    endtask

    initial begin
        exp_t r;
        rst = 1; frame_tick = 0; start = 0; abort = 0; x = 0; overlay_in = 0;
        model_reset();
        #3;
        r.off = SM; r.en = 0; r.busy = 0; r.done = 0;
        compare_outputs(r);
        @(negedge clk);
        rst = 0;

        // Full sequence, start pulse ahead of the first tick.
        cycle(0, 1, 0);
        tick_n(3);
        // offset is now 8: wrapped region is masked.
        @(negedge clk);
        x = 10'd3; overlay_in = 1;
        #1 check_eq("wrap_x_out", x_out, 1019);
        check_eq("wrap_masked", overlay_out, 0);
        x = 10'd8;
        #1 check_eq("edge_x_out", x_out, 0);
        check_eq("edge_visible", overlay_out, 1);
        x = 10'd0;
        tick_n(6);
        // In BLINK with text_en=1 after tick 9: overlay_out follows overlay_in.
        @(negedge clk);
        x = 10'd1023; overlay_in = 0;
        #1 check_eq("blink_in_low", overlay_out, 0);
        overlay_in = 1;
        #1 check_eq("blink_in_high", overlay_out, 1);
        x = 10'd0;
        tick_n(8);
        tick_n(2);

        // start+tick same cycle, start during SLIDE_IN ignored, abort with tick in HOLD.
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        tick_n(4);
        cycle(1, 0, 1);
        tick_n(20);

        // Pending start, abort in SLIDE_IN, start+abort same cycle.
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        tick_n(3);

        // Asynchronous reset mid SLIDE_OUT.
        cycle(1, 1, 0);
        tick_n(14);
        check_eq("in_slide_out", busy, 1);
        @(negedge clk);
        #2 rst = 1;
        model_reset();
        r.off = SM; r.en = 0; r.busy = 0; r.done = 0;
        compare_outputs(r);
        @(negedge clk);
        rst = 0;
        tick_n(2);

        // One more complete sequence after reset.
        cycle(1, 1, 0);
        tick_n(18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
